keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 16 +
 rtl/tickGen.sv | 38 +++
 rtl/keypad_scanner.sv | 178 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and default parameter values for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    localparam int DEF_CLK_DIV        = 48000;
    localparam int DEF_NUM_ROWS       = 4;
    localparam int DEF_NUM_COLS       = 4;
    localparam int DEF_DEBOUNCE_SCANS = 4;

endpackage

// File: rtl/tickGen.sv
// Free-running scan-rate divider: one-cycle tick on each wrap, frozen while en is low.
module tickGen
    import keypad_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == LAST);
    assign tick = en & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: walks one active-low row at a time, debounces the
// first key found, and reports it once on press; no rollover to other keys.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int NUM_ROWS       = DEF_NUM_ROWS,
    parameter int NUM_COLS       = DEF_NUM_COLS,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [NUM_COLS-1:0]                   cols,
    output logic [NUM_ROWS-1:0]                   rowDrive,
    output logic                                  tick,
    output logic                                  keyValid,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  keyCode,
    output logic                                  keyHeld,
    output key_state_e                            state_dbg
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int KEY_W = $clog2(NUM_ROWS * NUM_COLS);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    function automatic logic [KEY_W-1:0] key_code(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        return KEY_W'(r) * KEY_W'(NUM_COLS) + KEY_W'(c);
    endfunction

    key_state_e       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, row_next;
    logic [DB_W-1:0]  db_q, db_d, db_inc;
    logic [COL_W-1:0] cap_q, cap_d, low_col;
    logic [KEY_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [NUM_COLS-1:0] sync1_q, sync2_q;
    logic             any_low, cap_low, db_done;

    tickGen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    assign row_next = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    assign cap_low  = !sync2_q[cap_q];
    assign db_inc   = db_q + DB_W'(1);
    assign db_done  = (db_inc == DB_W'(DEBOUNCE_SCANS));

    // Lowest-index low column wins when several are pressed on the scanned row.
    always_comb begin
        any_low = 1'b0;
        low_col = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (!sync2_q[c]) begin
                any_low = 1'b1;
                low_col = COL_W'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        db_d    = db_q;
        cap_d   = cap_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        cap_d = low_col;
                        db_d  = DB_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = ST_HELD;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            code_d  = key_code(row_q, low_col);
                            db_d    = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        row_d = row_next;
                    end
                end
                ST_DEBOUNCE: begin
                    if (cap_low) begin
                        if (db_done) begin
                            state_d = ST_HELD;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            code_d  = key_code(row_q, cap_q);
                            db_d    = '0;
                        end else begin
                            db_d = db_inc;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        row_d   = row_next;
                        db_d    = '0;
                    end
                end
                ST_HELD: begin
                    if (!cap_low) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = ST_SCAN;
                            row_d   = row_next;
                            held_d  = 1'b0;
                            db_d    = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            db_d    = DB_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!cap_low) begin
                        if (db_done) begin
                            state_d = ST_SCAN;
                            row_d   = row_next;
                            held_d  = 1'b0;
                            db_d    = '0;
                        end else begin
                            db_d = db_inc;
                        end
                    end else begin
                        // Release bounce: back to held without re-reporting the key.
                        state_d = ST_HELD;
                        db_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    db_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCAN;
            row_q   <= '0;
            db_q    <= '0;
            cap_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            db_q    <= db_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            sync1_q <= cols;
            sync2_q <= sync1_q;
        end
    end

    assign rowDrive  = ~(NUM_ROWS'(1) << row_q);
    assign keyValid  = valid_q;
    assign keyCode   = code_q;
    assign keyHeld   = held_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random column patterns checked
// against a tick-level behavioural model of the keypad rules.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int DS = 3;

  logic clk;
  logic reset;
  logic en;
  logic [NC-1:0] cols;
  logic [NR-1:0] rowDrive;
  logic tick;
  logic keyValid;
  logic [3:0] keyCode;
  logic keyHeld;
  key_state_e state_dbg;

  int vectors;
  int miscompares;

  // scoreboard of key codes expected on keyValid pulses
  logic [3:0] exp_q[$];

  // behavioural model state
  int m_row;
  int m_have;
  int m_acc;
  int m_kcol;
  int m_agree;
  int m_rel;
  int m_code;
  int m_valid;

  keypad_scanner #(
    .CLK_DIV(CLK_DIV),
    .NUM_ROWS(NR),
    .NUM_COLS(NC),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .cols(cols),
    .rowDrive(rowDrive),
    .tick(tick),
    .keyValid(keyValid),
    .keyCode(keyCode),
    .keyHeld(keyHeld),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // scoreboard monitor: every keyValid pulse must match the next expected code
  always @(negedge clk) begin
    if (reset === 1'b1 && keyValid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL key_event: unexpected keyValid, keyCode=%0d, expected none", keyCode);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (keyCode !== e) begin
          miscompares++;
          $display("FAIL key_event: keyCode=%0d, expected %0d", keyCode, e);
        end
      end
    end
  end

  task automatic model_clear();
    m_row = 0; m_have = 0; m_acc = 0; m_kcol = 0;
    m_agree = 0; m_rel = 0; m_code = 0; m_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_accept();
    logic [3:0] k;
    m_acc = 1;
    m_valid = 1;
    m_rel = 0;
    m_code = m_row * NC + m_kcol;
    k = 4'(m_code);
    exp_q.push_back(k);
  endtask

  // one scan tick of the keypad rules, seen with column pattern c
  task automatic model_step(input logic [NC-1:0] c);
    int low;
    low = -1;
    for (int k = NC - 1; k >= 0; k--) if (c[k] == 1'b0) low = k;
    m_valid = 0;
    if (m_have == 0) begin
      if (low >= 0) begin
        m_have = 1; m_kcol = low; m_agree = 1; m_acc = 0; m_rel = 0;
        if (DS == 1) model_accept();
      end else begin
        m_row = (m_row + 1) % NR;
      end
    end else if (m_acc == 0) begin
      if (c[m_kcol] == 1'b0) begin
        m_agree++;
        if (m_agree >= DS) model_accept();
      end else begin
        m_have = 0;
        m_row = (m_row + 1) % NR;
      end
    end else begin
      if (c[m_kcol] == 1'b1) begin
        m_rel++;
        if (m_rel >= DS) begin
          m_have = 0; m_acc = 0;
          m_row = (m_row + 1) % NR;
        end
      end else begin
        m_rel = 0;
      end
    end
  endtask

  // driver: present c, wait for the next tick edge, then check the outputs after it
  task automatic step_tick(input logic [NC-1:0] c, output int waited);
    logic [NR-1:0] exp_rd;
    cols = c;
    waited = 0;
    while (tick !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL tick_timeout: tick=%b after %0d cycles, expected 1", tick, waited);
    end else begin
      model_step(c);
      @(posedge clk);
      @(negedge clk);
      exp_rd = ~(4'b0001 << m_row);
      vectors++;
      if (rowDrive !== exp_rd) begin
        miscompares++;
        $display("FAIL row_drive: rowDrive=%h, expected %h", rowDrive, exp_rd);
      end
      vectors++;
      if (keyValid !== 1'(m_valid)) begin
        miscompares++;
        $display("FAIL key_valid: keyValid=%b, expected %0d", keyValid, m_valid);
      end
      vectors++;
      if (keyHeld !== 1'(m_acc)) begin
        miscompares++;
        $display("FAIL key_held: keyHeld=%b, expected %0d", keyHeld, m_acc);
      end
      vectors++;
      if (keyCode !== 4'(m_code)) begin
        miscompares++;
        $display("FAIL key_code: keyCode=%0d, expected %0d", keyCode, m_code);
      end
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++;
        $display("FAIL tick_width: tick=%b one cycle after tick, expected 0", tick);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    cols = 4'hF;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (rowDrive !== 4'hE || tick !== 1'b0 || keyValid !== 1'b0 ||
        keyHeld !== 1'b0 || keyCode !== 4'h0 || state_dbg !== ST_SCAN) begin
      miscompares++;
      $display("FAIL reset_state: rowDrive=%h tick=%b valid=%b held=%b code=%0d state=%0d, expected E 0 0 0 0 0",
               rowDrive, tick, keyValid, keyHeld, keyCode, state_dbg);
    end
  endtask

  task automatic test_idle_scan();
    int w;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step_tick(4'hF, w);
      vectors++;
      if (w + 1 != CLK_DIV) begin
        miscompares++;
        $display("FAIL tick_period: period=%0d cycles, expected %0d", w + 1, CLK_DIV);
      end
    end
  endtask

  task automatic test_press();
    int w;
    apply_reset();
    step_tick(4'hF, w);
    repeat (4) step_tick(4'hB, w);
    vectors++;
    if (keyCode !== 4'd6 || keyHeld !== 1'b1 || rowDrive !== 4'hD) begin
      miscompares++;
      $display("FAIL press_row1: code=%0d held=%b rowDrive=%h, expected 6 1 D", keyCode, keyHeld, rowDrive);
    end
    repeat (3) step_tick(4'hF, w);
  endtask

  task automatic test_bounce_press();
    int w;
    apply_reset();
    step_tick(4'hD, w);
    step_tick(4'hF, w);
    vectors++;
    if (rowDrive !== 4'hD || keyHeld !== 1'b0 || state_dbg !== ST_SCAN) begin
      miscompares++;
      $display("FAIL short_press: rowDrive=%h held=%b state=%0d, expected D 0 0", rowDrive, keyHeld, state_dbg);
    end
  endtask

  task automatic test_lowest_col();
    int w;
    apply_reset();
    repeat (2) step_tick(4'hF, w);
    repeat (3) step_tick(4'h9, w);
    vectors++;
    if (keyCode !== 4'd9) begin
      miscompares++;
      $display("FAIL lowest_col: keyCode=%0d, expected 9", keyCode);
    end
    step_tick(4'hF, w);
    step_tick(4'h9, w);
    vectors++;
    if (keyHeld !== 1'b1) begin
      miscompares++;
      $display("FAIL release_bounce: keyHeld=%b, expected 1", keyHeld);
    end
    repeat (3) step_tick(4'hF, w);
    vectors++;
    if (keyHeld !== 1'b0 || rowDrive !== 4'h7) begin
      miscompares++;
      $display("FAIL release_done: held=%b rowDrive=%h, expected 0 7", keyHeld, rowDrive);
    end
  endtask

  task automatic test_enable_pause();
    int w;
    int bad;
    apply_reset();
    step_tick(4'hF, w);
    repeat (2) step_tick(4'hB, w);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick !== 1'b0 || state_dbg !== ST_DEBOUNCE || rowDrive !== 4'hD || keyValid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL enable_freeze: %0d cycles with activity while en=0, expected 0", bad);
    end
    en = 1'b1;
    step_tick(4'hB, w);
    vectors++;
    if (keyCode !== 4'd6 || keyHeld !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_resume: code=%0d held=%b, expected 6 1", keyCode, keyHeld);
    end
  endtask

  task automatic test_reset_held();
    int w;
    apply_reset();
    step_tick(4'hF, w);
    repeat (3) step_tick(4'h7, w);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (keyHeld !== 1'b0 || keyCode !== 4'h0 || rowDrive !== 4'hE || keyValid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: held=%b code=%0d rowDrive=%h valid=%b, expected 0 0 E 0",
               keyHeld, keyCode, rowDrive, keyValid);
    end
    cols = 4'hF;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) step_tick(4'hF, w);
  endtask

  task automatic test_random();
    int w;
    int r;
    logic [NC-1:0] c;
    apply_reset();
    c = 4'hF;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) c = c;
      else if (r < 6) c = 4'hF;
      else if (r < 9) c = ~(4'b0001 << $urandom_range(0, NC - 1));
      else c = 4'($urandom_range(0, 15));
      step_tick(c, w);
    end
    repeat (DS + 1) step_tick(4'hF, w);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    en = 1'b1;
    cols = 4'hF;
    model_clear();
    test_reset();
    test_idle_scan();
    test_press();
    test_bounce_press();
    test_lowest_col();
    test_enable_pause();
    test_reset_held();
    test_random();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: %0d expected keyValid pulses not seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
